// File: rtl/inst_fifo_mp_if.sv
// Bundle of fetch-side push lanes, issue-side pop lanes and status for inst_fifo_mp.
// master = fetch/issue logic driving the queue, slave = the queue itself.
interface inst_fifo_mp_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int PUSH_W = 2,
  parameter int POP_W  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PC_W  = $clog2(PUSH_W + 1);
  localparam int QC_W  = $clog2(POP_W + 1);

  logic                     flush;
  logic [PC_W-1:0]          push_cnt_i;
  logic [PUSH_W*DATA_W-1:0] push_data_i;
  logic [PUSH_W*ADDR_W-1:0] push_addr_i;
  logic [QC_W-1:0]          pop_cnt_i;
  logic [POP_W*DATA_W-1:0]  pop_data_o;
  logic [POP_W*ADDR_W-1:0]  pop_addr_o;
  logic [POP_W-1:0]         pop_valid_o;
  logic [CNT_W-1:0]         count_o;
  logic                     issue_ok_o;
  logic                     full_o;
  logic                     empty_o;
  logic                     ovf_o;
  logic                     udf_o;

  modport master (
    output flush, push_cnt_i, push_data_i, push_addr_i, pop_cnt_i,
    input  pop_data_o, pop_addr_o, pop_valid_o, count_o,
    input  issue_ok_o, full_o, empty_o, ovf_o, udf_o
  );

  modport slave (
    input  flush, push_cnt_i, push_data_i, push_addr_i, pop_cnt_i,
    output pop_data_o, pop_addr_o, pop_valid_o, count_o,
    output issue_ok_o, full_o, empty_o, ovf_o, udf_o
  );
endinterface

// File: rtl/inst_fifo_mp.sv
// Multi-port instruction queue: PUSH_W lanes in, POP_W head lanes out, explicit occupancy count.
// Define INST_FIFO_BYPASS_EN to forward push lanes straight to pop lanes while the queue is empty.
module inst_fifo_mp #(
  parameter int DEPTH    = 16,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int PUSH_W   = 2,
  parameter int POP_W    = 2,
  parameter int ISSUE_TH = 3
) (
  input logic           clk,
  input logic           rst,
  inst_fifo_mp_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PC_W  = $clog2(PUSH_W + 1);
  localparam int QC_W  = $clog2(POP_W + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next, tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next, udf_reg, udf_next;

  logic [SUM_W-1:0] push_n, pop_req, avail, pop_n, acc_n, skip_n, head_adv;
  logic             byp_active, accept, wr_en;

  logic [PUSH_W-1:0] lane_we;
  logic [PTR_W-1:0]  lane_idx [PUSH_W];

  always_comb begin
    push_n = (bus.push_cnt_i > PC_W'(PUSH_W)) ? SUM_W'(PUSH_W) : SUM_W'(bus.push_cnt_i);
    pop_req = (bus.pop_cnt_i > QC_W'(POP_W)) ? SUM_W'(POP_W) : SUM_W'(bus.pop_cnt_i);
`ifdef INST_FIFO_BYPASS_EN
    byp_active = (count_reg == '0) && !bus.flush;
`else
    byp_active = 1'b0;
`endif
    // While bypassing, the incoming lanes are what the consumer can pop.
    avail    = SUM_W'(count_reg) + (byp_active ? push_n : '0);
    pop_n    = (pop_req > avail) ? avail : pop_req;
    accept   = push_n <= (SUM_W'(DEPTH) - SUM_W'(count_reg) + pop_n);
    acc_n    = accept ? push_n : '0;
    skip_n   = byp_active ? pop_n : '0;
    head_adv = byp_active ? '0 : pop_n;
    wr_en    = accept && !bus.flush;

    head_next  = head_reg + PTR_W'(head_adv);
    tail_next  = tail_reg + PTR_W'(acc_n - skip_n);
    count_next = CNT_W'(SUM_W'(count_reg) + acc_n - pop_n);
    ovf_next   = ovf_reg | !accept;
    udf_next   = udf_reg | (pop_req > avail);

    if (bus.flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
      ovf_next   = ovf_reg;
      udf_next   = udf_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      udf_reg   <= udf_next;
    end
  end

  // Lanes already consumed through the bypass are skipped; the rest pack from tail upward.
  for (genvar gi = 0; gi < PUSH_W; gi++) begin : g_wr
    assign lane_we[gi]  = wr_en && (SUM_W'(gi) >= skip_n) && (SUM_W'(gi) < acc_n);
    assign lane_idx[gi] = tail_reg + PTR_W'(SUM_W'(gi) - skip_n);
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < PUSH_W; k++) begin
      if (lane_we[k]) begin
        data_mem[lane_idx[k]] <= bus.push_data_i[k*DATA_W +: DATA_W];
        addr_mem[lane_idx[k]] <= bus.push_addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  for (genvar gi = 0; gi < POP_W; gi++) begin : g_rd
    logic [PTR_W-1:0] rd_idx;
    assign rd_idx = head_reg + PTR_W'(gi);
`ifdef INST_FIFO_BYPASS_EN
    if (gi < PUSH_W) begin : g_byp
      assign bus.pop_data_o[gi*DATA_W +: DATA_W] =
        byp_active ? bus.push_data_i[gi*DATA_W +: DATA_W] : data_mem[rd_idx];
      assign bus.pop_addr_o[gi*ADDR_W +: ADDR_W] =
        byp_active ? bus.push_addr_i[gi*ADDR_W +: ADDR_W] : addr_mem[rd_idx];
      assign bus.pop_valid_o[gi] =
        byp_active ? (push_n > SUM_W'(gi)) : (count_reg > CNT_W'(gi));
    end else begin : g_mem
      assign bus.pop_data_o[gi*DATA_W +: DATA_W] = data_mem[rd_idx];
      assign bus.pop_addr_o[gi*ADDR_W +: ADDR_W] = addr_mem[rd_idx];
      assign bus.pop_valid_o[gi] = count_reg > CNT_W'(gi);
    end
`else
    assign bus.pop_data_o[gi*DATA_W +: DATA_W] = data_mem[rd_idx];
    assign bus.pop_addr_o[gi*ADDR_W +: ADDR_W] = addr_mem[rd_idx];
    assign bus.pop_valid_o[gi] = count_reg > CNT_W'(gi);
`endif
  end

  assign bus.count_o    = count_reg;
  assign bus.empty_o    = (count_reg == '0);
  assign bus.full_o     = (SUM_W'(DEPTH) - SUM_W'(count_reg)) < SUM_W'(PUSH_W);
  assign bus.issue_ok_o = count_reg >= CNT_W'(ISSUE_TH);
  assign bus.ovf_o      = ovf_reg;
  assign bus.udf_o      = udf_reg;
endmodule
